// File: rtl/pipeline_ctrl.sv
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : 5-stage pipeline stall/flush controller with MEM-stage SRAM
//                wait handling. Define SRAM_READY_EN for handshake-driven waits.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
   parameter int MEM_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard,
   input  logic             branch_taken,
   input  logic             mem_access,
   input  logic             sram_ready,
   output logic             pc_freeze,
   output logic             if_freeze,
   output logic             if_flush,
   output logic             id_flush,
   output logic             back_freeze,
   output logic             mem_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_freeze;

`ifdef SRAM_READY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_freeze    = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         RUN: begin
            if (mem_access && !sram_ready) begin
               w_freeze    = 1'b1;
               w_state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (!sram_ready) begin
               w_freeze = 1'b1;
            end else begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = RUN;
      endcase
   end
`else
   localparam logic [7:0] LAT_M1 = 8'(MEM_LAT - 1);
   localparam bit         STALLS = (MEM_LAT > 1);

   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_nxt;
   logic       unused_sram_ready;

   assign unused_sram_ready = sram_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // The cycle where wait_cnt reaches MEM_LAT-1 is the release cycle: the
   // access completes there, so the pipe runs and the branch/hazard rules apply.
   always_comb begin
      w_freeze    = 1'b0;
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      case (r_state)
         RUN: begin
            if (mem_access && STALLS) begin
               w_freeze    = 1'b1;
               w_state_nxt = MEM_WAIT;
               w_wait_nxt  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (r_wait_cnt < LAT_M1) begin
               w_freeze   = 1'b1;
               w_wait_nxt = r_wait_cnt + 8'd1;
            end else begin
               w_state_nxt = RUN;
               w_wait_nxt  = 8'd0;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_wait_nxt  = 8'd0;
         end
      endcase
   end
`endif

   // Priority: SRAM freeze, then taken branch, then load-use hazard.
   always_comb begin
      pc_freeze   = 1'b0;
      if_freeze   = 1'b0;
      if_flush    = 1'b0;
      id_flush    = 1'b0;
      back_freeze = 1'b0;
      mem_busy    = 1'b0;
      if (!rst) begin
         if (w_freeze) begin
            pc_freeze   = 1'b1;
            if_freeze   = 1'b1;
            back_freeze = 1'b1;
            mem_busy    = 1'b1;
         end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
         end else if (hazard) begin
            pc_freeze = 1'b1;
            if_freeze = 1'b1;
            id_flush  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (pc_freeze && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl (MEM_LAT=4 and MEM_LAT=1
//                instances) against a countdown-based reference model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hazard = 1'b0, branch_taken = 1'b0, mem_access = 1'b0, sram_ready = 1'b0;

   logic a_pc, a_iff, a_ifl, a_idf, a_bf, a_mb;
   logic b_pc, b_iff, b_ifl, b_idf, b_bf, b_mb;
   logic [15:0] a_cnt;
   logic [3:0]  b_cnt;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MEM_LAT(4), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
      .mem_access(mem_access), .sram_ready(sram_ready),
      .pc_freeze(a_pc), .if_freeze(a_iff), .if_flush(a_ifl), .id_flush(a_idf),
      .back_freeze(a_bf), .mem_busy(a_mb), .stall_cnt(a_cnt));

   pipeline_ctrl #(.MEM_LAT(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
      .mem_access(mem_access), .sram_ready(sram_ready),
      .pc_freeze(b_pc), .if_freeze(b_iff), .if_flush(b_ifl), .id_flush(b_idf),
      .back_freeze(b_bf), .mem_busy(b_mb), .stall_cnt(b_cnt));

   // Control vector order: {pc_freeze, if_freeze, if_flush, id_flush, back_freeze, mem_busy}
   logic [5:0]  act_ctl [2];
   logic [15:0] act_cnt [2];
   always_comb begin
      act_ctl[0] = {a_pc, a_iff, a_ifl, a_idf, a_bf, a_mb};
      act_ctl[1] = {b_pc, b_iff, b_ifl, b_idf, b_bf, b_mb};
      act_cnt[0] = a_cnt;
      act_cnt[1] = {12'd0, b_cnt};
   end

   int checks = 0;
   int fails  = 0;

   // Reference model: an access costs (lat-1) frozen cycles, then one release cycle.
   int         lat  [2] = '{4, 1};
   int         cmax [2] = '{65535, 15};
   int         stall_left [2];
   bit         rel  [2];
   bit         busy [2];
   int         cnt  [2];
   logic [5:0] exp_ctl [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         stall_left[i] = 0;
         rel[i]        = 1'b0;
         busy[i]       = 1'b0;
         cnt[i]        = 0;
      end
   endtask

   task automatic model_eval();
      bit fz;
      for (int i = 0; i < 2; i++) begin
`ifdef SRAM_READY_EN
         fz = busy[i] ? !sram_ready : (mem_access && !sram_ready);
`else
         if (stall_left[i] > 0)  fz = 1'b1;
         else if (rel[i])        fz = 1'b0;
         else                    fz = mem_access && (lat[i] > 1);
`endif
         if (rst)               exp_ctl[i] = 6'b000000;
         else if (fz)           exp_ctl[i] = 6'b110011;
         else if (branch_taken) exp_ctl[i] = 6'b001100;
         else if (hazard)       exp_ctl[i] = 6'b110100;
         else                   exp_ctl[i] = 6'b000000;
         busy[i] = busy[i];
      end
   endtask

   task automatic model_clock();
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            stall_left[i] = 0; rel[i] = 1'b0; busy[i] = 1'b0; cnt[i] = 0;
         end else begin
            if (exp_ctl[i][5] && cnt[i] < cmax[i]) cnt[i]++;
`ifdef SRAM_READY_EN
            if (busy[i]) begin
               if (sram_ready) busy[i] = 1'b0;
            end else if (mem_access && !sram_ready) begin
               busy[i] = 1'b1;
            end
`else
            if (stall_left[i] > 0) begin
               stall_left[i]--;
               if (stall_left[i] == 0) rel[i] = 1'b1;
            end else if (rel[i]) begin
               rel[i] = 1'b0;
            end else if (mem_access && lat[i] > 1) begin
               stall_left[i] = lat[i] - 2;
               rel[i]        = (stall_left[i] == 0);
            end
`endif
         end
      end
   endtask

   task automatic cyc(input bit h, input bit b, input bit m, input bit s);
      hazard = h; branch_taken = b; mem_access = m; sram_ready = s;
      @(negedge clk);
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic test_reset();
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act_ctl[i] !== 6'b000000 || act_cnt[i] !== 16'd0) begin
            fails++;
            $display("FAIL reset dut%0d ctl=%b cnt=%0d required ctl=000000 cnt=0", i, act_ctl[i], act_cnt[i]);
         end
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_mem_stall();
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, k < 4, 1'b0);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctl[i] !== exp_ctl[i] || act_cnt[i] !== 16'(cnt[i])) begin
               fails++;
               $display("FAIL mem_stall k=%0d dut%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d", k, i, act_ctl[i], act_cnt[i], exp_ctl[i], cnt[i]);
            end
         end
`ifndef SRAM_READY_EN
         checks++;
         if (a_bf !== (k < 3)) begin
            fails++;
            $display("FAIL mem_stall_back_freeze t%0d got=%b required=%b", k, a_bf, (k < 3));
         end
         if (k == 4) begin
            checks++;
            if (a_cnt !== 16'd3) begin
               fails++;
               $display("FAIL mem_stall_count got=%0d required=3", a_cnt);
            end
         end
`endif
         tick();
      end
   endtask

   task automatic test_hazard();
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({a_pc, a_iff, a_idf, a_bf, a_ifl} !== 5'b11100) begin
         fails++;
         $display("FAIL hazard pc/iff/idf/bf/ifl=%b required=11100", {a_pc, a_iff, a_idf, a_bf, a_ifl});
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act_ctl[i] !== exp_ctl[i] || act_cnt[i] !== 16'(cnt[i])) begin
            fails++;
            $display("FAIL hazard dut%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, act_ctl[i], act_cnt[i], exp_ctl[i], cnt[i]);
         end
      end
      tick();
   endtask

   task automatic test_branch_hazard();
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({a_pc, a_ifl, a_idf} !== 3'b011) begin
         fails++;
         $display("FAIL branch_hazard pc/ifl/idf=%b required=011", {a_pc, a_ifl, a_idf});
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act_ctl[i] !== exp_ctl[i] || act_cnt[i] !== 16'(cnt[i])) begin
            fails++;
            $display("FAIL branch_hazard dut%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d", i, act_ctl[i], act_cnt[i], exp_ctl[i], cnt[i]);
         end
      end
      tick();
   endtask

   task automatic test_branch_in_wait();
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b0);
`ifndef SRAM_READY_EN
         checks++;
         if ({a_ifl, a_idf} !== ((k == 3) ? 2'b11 : 2'b00)) begin
            fails++;
            $display("FAIL branch_in_wait t%0d flushes=%b required=%b", k, {a_ifl, a_idf}, ((k == 3) ? 2'b11 : 2'b00));
         end
`endif
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctl[i] !== exp_ctl[i] || act_cnt[i] !== 16'(cnt[i])) begin
               fails++;
               $display("FAIL branch_in_wait k=%0d dut%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d", k, i, act_ctl[i], act_cnt[i], exp_ctl[i], cnt[i]);
            end
         end
         tick();
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_reset_mid_wait();
      int nfz;
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
         tick();
      end
      #2 rst = 1'b1;
      model_reset();
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (act_ctl[i] !== 6'b000000 || act_cnt[i] !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid_wait dut%0d ctl=%b cnt=%0d required ctl=000000 cnt=0", i, act_ctl[i], act_cnt[i]);
         end
      end
      @(posedge clk);
      model_clock();
      #1 rst = 1'b0;
      nfz = 0;
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, 1'b0, k < 4, 1'b0);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctl[i] !== exp_ctl[i] || act_cnt[i] !== 16'(cnt[i])) begin
               fails++;
               $display("FAIL reset_mid_wait k=%0d dut%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d", k, i, act_ctl[i], act_cnt[i], exp_ctl[i], cnt[i]);
            end
         end
         nfz += int'(a_pc);
         tick();
      end
`ifndef SRAM_READY_EN
      checks++;
      if (nfz != 3) begin
         fails++;
         $display("FAIL reset_mid_wait_stalls got=%0d required=3", nfz);
      end
`endif
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 20; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctl[i] !== exp_ctl[i] || act_cnt[i] !== 16'(cnt[i])) begin
               fails++;
               $display("FAIL saturation k=%0d dut%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d", k, i, act_ctl[i], act_cnt[i], exp_ctl[i], cnt[i]);
            end
         end
         tick();
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (b_cnt !== 4'd15) begin
         fails++;
         $display("FAIL saturation_cnt got=%0d required=15", b_cnt);
      end
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctl[i] !== exp_ctl[i] || act_cnt[i] !== 16'(cnt[i])) begin
               fails++;
               $display("FAIL random k=%0d dut%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d", k, i, act_ctl[i], act_cnt[i], exp_ctl[i], cnt[i]);
            end
         end
         tick();
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

`ifdef SRAM_READY_EN
   task automatic test_sram_ready();
      int nfz;
      nfz = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(1'b0, 1'b0, 1'b1, k >= 6);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_ctl[i] !== exp_ctl[i] || act_cnt[i] !== 16'(cnt[i])) begin
               fails++;
               $display("FAIL sram_ready k=%0d dut%0d ctl=%b cnt=%0d expected ctl=%b cnt=%0d", k, i, act_ctl[i], act_cnt[i], exp_ctl[i], cnt[i]);
            end
         end
         nfz += int'(a_pc);
         tick();
      end
      checks++;
      if (nfz != 6) begin
         fails++;
         $display("FAIL sram_ready_stalls got=%0d required=6", nfz);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_mem_stall();
      test_hazard();
      test_branch_hazard();
      test_branch_in_wait();
      test_reset_mid_wait();
      test_saturation();
      test_random();
`ifdef SRAM_READY_EN
      test_sram_ready();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 4, cycles one MEM-stage SRAM access occupies, legal range 1..255.
REQ-002 Parameter CNT_W, default 16, width of stall_cnt.
REQ-003 One clock, clk; reset rst is asynchronous, active-high.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 hazard  input  1  ID operand depends on an in-flight EX/MEM destination.
REQ-007 branch_taken  input  1  EX-stage branch resolved taken.
REQ-008 mem_access  input  1  MEM stage holds a load/store.
REQ-009 sram_ready  input  1  SRAM access complete; used only under SRAM_READY_EN.
REQ-010 pc_freeze  output  1  PC register holds.
REQ-011 if_freeze  output  1  IF/ID register holds.
REQ-012 if_flush  output  1  IF/ID register loads zero (bubble).
REQ-013 id_flush  output  1  ID/EX register loads zero (bubble).
REQ-014 back_freeze  output  1  ID/EX, EX/MEM, MEM/WB registers hold.
REQ-015 mem_busy  output  1  SRAM access in progress, pipeline frozen.
REQ-016 stall_cnt  output  CNT_W  count of cycles with pc_freeze high.

Function
REQ-017 FSM states RUN, MEM_WAIT; internal wait_cnt, 8 bits.
REQ-018 Freeze cycle = (RUN and mem_access and MEM_LAT>1) or (MEM_WAIT and wait_cnt<MEM_LAT-1); outputs combinational from state, wait_cnt, inputs.
REQ-019 Freeze cycle: pc_freeze, if_freeze, back_freeze, mem_busy = 1; if_flush, id_flush = 0; branch_taken and hazard ignored.
REQ-020 RUN with mem_access and MEM_LAT>1: next state MEM_WAIT, wait_cnt <= 1.
REQ-021 MEM_WAIT: wait_cnt increments per cycle; cycle with wait_cnt==MEM_LAT-1 is release cycle, all freezes 0, next state RUN.
REQ-022 Access therefore stalls exactly MEM_LAT-1 cycles; MEM_LAT=1 never stalls.
REQ-023 Non-freeze cycle, branch_taken=1: pc_freeze=0, if_flush=1, id_flush=1, if_freeze=0; hazard ignored (branch wins).
REQ-024 Non-freeze cycle, hazard=1, branch_taken=0: pc_freeze=1, if_freeze=1, id_flush=1, if_flush=0, back_freeze=0.
REQ-025 Non-freeze cycle, neither: all control outputs 0.
REQ-026 Release cycle evaluates branch_taken/hazard per REQ-023/024.
REQ-027 Back-to-back accesses: mem_access high in cycle after release starts a new wait (new instruction).
REQ-028 stall_cnt increments on each rising edge where pc_freeze=1; saturates at all-ones, no wrap.

Reset
REQ-029 rst high: state RUN, wait_cnt 0, stall_cnt 0 immediately, no clock needed.
REQ-030 While rst high all freeze/flush outputs and mem_busy are 0.
REQ-031 rst mid-MEM_WAIT abandons access; first cycle after release obeys RUN rules.

Configuration
REQ-032 Macro SRAM_READY_EN defined: freeze cycle = (RUN and mem_access and !sram_ready) or (MEM_WAIT and !sram_ready); MEM_WAIT exits to RUN on cycle sram_ready=1 (release cycle); MEM_LAT, wait_cnt unused.
REQ-033 SRAM_READY_EN undefined: fixed-latency counter per REQ-018..022; sram_ready ignored.

Verification
REQ-034 MEM_LAT=4, mem_access pulse 1 cycle at t0 then held by frozen pipe -> back_freeze=1 at t0..t2, 0 at t3; stall_cnt=3.
REQ-035 hazard=1 one cycle, no access -> pc_freeze=1, if_freeze=1, id_flush=1, back_freeze=0 that cycle.
REQ-036 branch_taken=1 and hazard=1 same cycle -> if_flush=1, id_flush=1, pc_freeze=0.
REQ-037 branch_taken=1 during MEM_WAIT (MEM_LAT=4) -> no flush until release cycle, flushes=1 there.
REQ-038 rst asserted at wait_cnt=2 -> outputs 0 asynchronously, stall_cnt=0, next access stalls full 3 cycles.
REQ-039 CNT_W=4, hazard held 20 cycles -> stall_cnt saturates at 15; SRAM_READY_EN build, sram_ready high after 6 cycles -> 6 freeze cycles.
